mem_arbiter: RTL and testbench

- Shares the single memory_unit port between two requesters: M0 (CPU fetch/load/store path) and M1 (DMA/program loader).
- Registered-grant, two-way round-robin arbiter with optional locked bursts, bounded by MAX_BURST.
- Sits between the requesters and memory_unit. The CPU control unit holds its current state while m0_gnt is low.

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
package mem_arbiter_pkg;

  // Owner encoding, also exported on the debug owner port.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,   // 1: M1 was granted last, 0: M0 was granted last
  output logic [1:0] pick_o
);

  // Lone requester wins outright; a tie goes to the one that did not go last.
  always_comb begin
    pick_o = OWNER_NONE;
    if (req0_i && (!req1_i || last_i)) pick_o = OWNER_M0;
    else if (req1_i)                   pick_o = OWNER_M1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Registered-grant round-robin arbiter sharing one memory port between M0 (CPU)
// and M1 (DMA/loader), with locked bursts bounded by MAX_BURST.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int             BW         = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

  logic [1:0]    owner_q;
  logic          last_q;    // 1: M1 granted last
  logic [BW-1:0] beats_q;

  logic          pick_last;
  logic [1:0]    pick;
  logic          keep;

  // Grants are pure decodes of the owner register, so reset drops them at once.
  assign m0_gnt = (owner_q == OWNER_M0);
  assign m1_gnt = (owner_q == OWNER_M1);
  assign owner  = owner_q;

  assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign mem_we    = (m0_gnt & m0_req & m0_we) | (m1_gnt & m1_req & m1_we);
  assign rdata     = mem_rdata;

  // While someone owns the port, treat the owner as "last" so a release hands
  // over to the other requester first and only falls back to a fresh tenure.
  assign pick_last = (owner_q == OWNER_NONE) ? last_q : m1_gnt;

  rr_pick2 u_pick (
    .req0_i (m0_req),
    .req1_i (m1_req),
    .last_i (pick_last),
    .pick_o (pick)
  );

  // Owner holds a locked tenure until the burst limit, unless nobody else waits.
  always_comb begin
    keep = 1'b0;
    if (m0_gnt) keep = m0_req & m0_lock & ((beats_q < BURST_LAST) | ~m1_req);
    if (m1_gnt) keep = m1_req & m1_lock & ((beats_q < BURST_LAST) | ~m0_req);
  end

  // Arbitration state: extend a locked tenure or re-arbitrate with no idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWNER_NONE;
      last_q  <= 1'b1;
      beats_q <= '0;
    end else if (keep) begin
      if (beats_q != '1) beats_q <= beats_q + BW'(1);
    end else begin
      owner_q <= pick;
      beats_q <= '0;
      if (pick != OWNER_NONE) last_q <= (pick == OWNER_M1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory behind the port.
module tb_mem_arbiter;

  localparam logic [1:0] ONONE = 2'b00;
  localparam logic [1:0] OM0   = 2'b01;
  localparam logic [1:0] OM1   = 2'b10;

  logic        clk, rst;
  logic        m0_req, m0_lock, m0_we, m0_gnt;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_lock, m1_we, m1_gnt;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational-read memory, write commits at the posedge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Owner register and both grant decodes in one comparison.
  task automatic chk_own(input string tag, input logic [1:0] exp);
    logic [3:0] o, e;
    o = {m1_gnt, m0_gnt, owner};
    e = {exp == OM1, exp == OM0, exp};
    chk(tag, 32'(o), 32'(e));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h1234_5678;
    rst = 1'b1;
    m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;

    // Reset with both requesting: nothing granted, no write.
    cyc(); cyc();
    chk_own("rst_owner", ONONE);
    chk("rst_mem_we", 32'(mem_we), 32'd0);

    // Release: M0 wins the first tie, then strict alternation.
    m0_we = 1'b0;
    rst = 1'b0;
    cyc(); chk_own("first_m0", OM0);
    cyc(); chk_own("alt_1", OM1);
    cyc(); chk_own("alt_2", OM0);
    cyc(); chk_own("alt_3", OM1);
    cyc(); chk_own("alt_4", OM0);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(); chk_own("idle", ONONE);

    // Single M0 read: granted one cycle later, then every cycle.
    m0_req = 1'b1; m0_addr = 32'h0001_0000;
    #1 chk_own("m0_req_cycle_n", ONONE);
    chk("mux_default_m0", mem_addr, 32'h0001_0000);
    cyc(); chk_own("m0_n_plus_1", OM0);
    chk("m0_rd_addr", mem_addr, 32'h0001_0000);
    chk("m0_rdata", rdata, 32'h1234_5678);
    cyc(); chk_own("m0_regrant", OM0);
    m0_req = 1'b0;
    cyc(); chk_own("idle2", ONONE);

    // Locked M1 burst against waiting M0: 4 beats of M1, 1 of M0, M1 again.
    m1_req = 1'b1; m1_lock = 1'b1; m0_req = 1'b1;
    cyc(); chk_own("burst_b1", OM1);
    cyc(); chk_own("burst_b2", OM1);
    cyc(); chk_own("burst_b3", OM1);
    cyc(); chk_own("burst_b4", OM1);
    cyc(); chk_own("burst_m0", OM0);
    cyc(); chk_own("burst_m1_again", OM1);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    cyc(); chk_own("idle3", ONONE);

    // M1 write; M0 write enable without a grant must not reach memory.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'hDEAD_BEEF;
    m0_we = 1'b1;
    #1 chk("m0_we_no_gnt", 32'(mem_we), 32'd0);
    cyc(); chk_own("wr_gnt", OM1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_addr", mem_addr, 32'h0000_0100);
    chk("wr_data", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    // Still granted after the committing edge, but request withdrawn: no write.
    m1_req = 1'b0;
    #1 chk_own("withdrawn_gnt", OM1);
    chk("withdrawn_no_we", 32'(mem_we), 32'd0);
    m1_we = 1'b0; m0_we = 1'b0; m0_req = 1'b1; m0_addr = 32'h0000_0100;
    cyc(); chk_own("rd_back_gnt", OM0);
    chk("rd_back_data", rdata, 32'hDEAD_BEEF);
    chk("rd_back_no_we", 32'(mem_we), 32'd0);
    m0_req = 1'b0;
    cyc(); chk_own("idle4", ONONE);

    // Reset during beat 2 of a locked M1 write burst.
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h0000_0104; m1_wdata = 32'h1111_1111;
    cyc(); chk_own("rb_beat1", OM1);
    chk("rb_beat1_we", 32'(mem_we), 32'd1);
    cyc();
    m1_wdata = 32'h2222_2222;
    #1 chk_own("rb_beat2", OM1);
    chk("rb_beat2_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1 chk_own("rb_async_drop", ONONE);
    chk("rb_we_drop", 32'(mem_we), 32'd0);
    cyc();
    m1_lock = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0104;
    rst = 1'b0;
    cyc(); chk_own("rb_m0_first", OM0);
    chk("rb_no_write", rdata, 32'h1111_1111);
    cyc(); chk_own("rb_then_m1", OM1);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
